tmr_vote_scrubber: RTL and testbench
====================================

Name: tmr_vote_scrubber

Overview:
- Sits directly downstream of a TMR-enabled register stage. Consumes its three redundant copies and produces a registered bitwise-majority value.
- Detects copy disagreement and issues a scrub (write-back) request with a req/ack handshake back to the register stage.
- Counts correction events and flags a sticky fault if the register stage never acknowledges a scrub.

Parameters:
- WIDTH, 8, width of each register copy and of the voted output.
- ERR_CNT_W, 8, width of the saturating correction-event counter.
- SCRUB_TIMEOUT, 15, max cycles in REQ without scrub_ack before FAULT (legal range 1..255).
- SETTLE_CYC, 2, cycles after ack during which mismatches are ignored (legal range 1..15).

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- copy_a, input, WIDTH, register copy A.
- copy_b, input, WIDTH, register copy B.
- copy_c, input, WIDTH, register copy C.
- voted, output, WIDTH, registered bitwise majority of A/B/C.
- mismatch, output, 1, registered: copies disagreed in the previous cycle.
- scrub_req, output, 1, request to rewrite all copies with scrub_data.
- scrub_data, output, WIDTH, value to write back; stable while scrub_req is high.
- scrub_ack, input, 1, register stage accepted the scrub.
- clr, input, 1, clears err_count, err_sat, timeout_err; exits FAULT.
- err_count, output, ERR_CNT_W, number of scrub events started; saturating.
- err_sat, output, 1, sticky: err_count reached all-ones.
- timeout_err, output, 1, sticky: scrub not acknowledged within SCRUB_TIMEOUT.

Behaviour:
- Reset (rst_n low at a clk edge): voted=0, mismatch=0, scrub_req=0, scrub_data=0, err_count=0, err_sat=0, timeout_err=0, FSM=IDLE, timers=0. Reset overrides everything, including mid-handshake: scrub_req drops on that edge.
- Vote: voted <= (A&B)|(B&C)|(A&C). Latency 1 cycle, updated every cycle in all states.
- Mismatch: mismatch <= (A!=B)|(B!=C). Latency 1 cycle, updated every cycle in all states, including FAULT.
- Mismatch is evaluated combinationally on the current inputs ("mis_now") for FSM decisions.
- FSM states: IDLE, REQ, SETTLE, FAULT.
- IDLE:
  - If mis_now: scrub_data <= majority(current inputs), scrub_req <= 1, timer <= 0, err_count increments, go REQ.
  - Else stay in IDLE.
- REQ:
  - scrub_req and scrub_data are held constant; input changes do not alter scrub_data.
  - If scrub_ack: scrub_req <= 0, settle timer <= 0, go SETTLE.
  - Else if timer == SCRUB_TIMEOUT-1: scrub_req <= 0, timeout_err <= 1, go FAULT.
  - Else timer increments.
  - Ack arriving on the timeout cycle counts as success (ack has priority).
- SETTLE:
  - mis_now is ignored.
  - After SETTLE_CYC cycles, go IDLE. A mismatch present on the first IDLE cycle starts a new scrub.
- FAULT:
  - scrub_req stays 0, no scrubbing; voted and mismatch keep updating.
  - Leaves to IDLE only on clr.
- scrub_ack outside REQ is ignored.
- err_count: increments by 1 on each IDLE->REQ transition and holds at all-ones. err_sat <= 1 on the increment that reaches all-ones.
- clr (any state): clears err_count, err_sat, timeout_err. If an increment coincides with clr, clr wins (count=0).
- clr in REQ or SETTLE does not abort the handshake.

Test Plan:
- Reset and clean input: rst_n low 2 cycles, then A=B=C=8'h5A -> voted=8'h5A one cycle later; mismatch=0; scrub_req=0; err_count=0.
- Single-copy upset: A=B=8'h5A, C=8'h7A in one cycle -> next cycle voted=8'h5A, mismatch=1, scrub_req=1, scrub_data=8'h5A, err_count=1. Ack 3 cycles later -> scrub_req=0 next cycle. Mismatch ignored for 2 cycles, then IDLE.
- scrub_data stability: while in REQ, change inputs to 8'hFF/8'h00/8'hFF -> scrub_data stays 8'h5A until ack.
- Timeout: mismatch with no ack -> after 15 cycles in REQ scrub_req=0, timeout_err=1, FSM FAULT. Further mismatches give no scrub_req. clr -> timeout_err=0, err_count=0, back to IDLE.
- Counter saturation (ERR_CNT_W=2): 4 acked scrub events -> err_count=3, err_sat=1 after the third; fourth leaves count at 3. clr on the same cycle as a fifth event start -> err_count=0.
- Reset mid-handshake: scrub_req=1 in REQ, assert rst_n low -> scrub_req=0 at that edge; all outputs at reset values; FSM IDLE.

Source files
------------

// File: rtl/tmr_vote_scrubber.sv
// tmr_vote_scrubber
// Votes three redundant register copies into one registered value. When the
// copies disagree it requests a write-back of the voted value (req/ack) and
// counts the correction events. If the register stage never acknowledges a
// write-back, it raises a sticky timeout flag and parks in a fault state.
module tmr_vote_scrubber #(
    parameter int WIDTH         = 8,
    parameter int ERR_CNT_W     = 8,
    parameter int SCRUB_TIMEOUT = 15,
    parameter int SETTLE_CYC    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     copy_a,
    input  logic [WIDTH-1:0]     copy_b,
    input  logic [WIDTH-1:0]     copy_c,
    output logic [WIDTH-1:0]     voted,
    output logic                 mismatch,
    output logic                 scrub_req,
    output logic [WIDTH-1:0]     scrub_data,
    input  logic                 scrub_ack,
    input  logic                 clr,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 err_sat,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SETTLE,
        ST_FAULT
    } state_t;

    localparam logic [7:0]           TIMEOUT_LAST = 8'(SCRUB_TIMEOUT - 1);
    localparam logic [3:0]           SETTLE_LAST  = 4'(SETTLE_CYC - 1);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX      = '1;

    state_t               state_reg;
    logic [7:0]           timer_reg;
    logic [3:0]           settle_reg;
    logic [WIDTH-1:0]     voted_reg;
    logic                 mismatch_reg;
    logic                 scrub_req_reg;
    logic [WIDTH-1:0]     scrub_data_reg;
    logic [ERR_CNT_W-1:0] err_count_reg;
    logic                 err_sat_reg;
    logic                 timeout_err_reg;

    logic [WIDTH-1:0]     maj_now;
    logic                 mis_now;
    logic                 start_scrub;
    logic                 timeout_hit;

    // Per-bit 2-of-3 majority of the live inputs.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_vote
            assign maj_now[gi] = (copy_a[gi] & copy_b[gi])
                               | (copy_b[gi] & copy_c[gi])
                               | (copy_a[gi] & copy_c[gi]);
        end
    endgenerate

    assign mis_now     = (copy_a != copy_b) | (copy_b != copy_c);
    assign start_scrub = (state_reg == ST_IDLE) && mis_now;
    assign timeout_hit = (state_reg == ST_REQ) && !scrub_ack && (timer_reg == TIMEOUT_LAST);

    // Voted value and disagreement flag track the inputs every cycle, in every state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            voted_reg    <= '0;
            mismatch_reg <= 1'b0;
        end else begin
            voted_reg    <= maj_now;
            mismatch_reg <= mis_now;
        end
    end

    // Scrub handshake FSM: request, wait for ack (bounded), then let the copies settle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            timer_reg      <= '0;
            settle_reg     <= '0;
            scrub_req_reg  <= 1'b0;
            scrub_data_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mis_now) begin
                        scrub_data_reg <= maj_now;
                        scrub_req_reg  <= 1'b1;
                        timer_reg      <= '0;
                        state_reg      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Ack wins over a timeout landing on the same cycle.
                    if (scrub_ack) begin
                        scrub_req_reg <= 1'b0;
                        settle_reg    <= '0;
                        state_reg     <= ST_SETTLE;
                    end else if (timer_reg == TIMEOUT_LAST) begin
                        scrub_req_reg <= 1'b0;
                        state_reg     <= ST_FAULT;
                    end else begin
                        timer_reg <= timer_reg + 8'd1;
                    end
                end
                ST_SETTLE: begin
                    // The rewrite takes effect over the next few cycles; ignore disagreement meanwhile.
                    if (settle_reg == SETTLE_LAST) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        settle_reg <= settle_reg + 4'd1;
                    end
                end
                ST_FAULT: begin
                    if (clr) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    scrub_req_reg <= 1'b0;
                end
            endcase
        end
    end

    // Event counter and sticky flags; clr beats any simultaneous increment or set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_reg   <= '0;
            err_sat_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else if (clr) begin
            err_count_reg   <= '0;
            err_sat_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (start_scrub && (err_count_reg != CNT_MAX)) begin
                err_count_reg <= err_count_reg + 1'b1;
                if (err_count_reg == CNT_MAX - 1'b1) begin
                    err_sat_reg <= 1'b1;
                end
            end
            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign voted       = voted_reg;
    assign mismatch    = mismatch_reg;
    assign scrub_req   = scrub_req_reg;
    assign scrub_data  = scrub_data_reg;
    assign err_count   = err_count_reg;
    assign err_sat     = err_sat_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_tmr_vote_scrubber.sv
// Testbench for tmr_vote_scrubber: directed scenarios followed by random
// traffic. A driver steps a behavioural model alongside the stimulus and
// queues the expected outputs; a monitor compares them one cycle later.
module tb_tmr_vote_scrubber;

    localparam int WIDTH         = 8;
    localparam int ERR_CNT_W     = 2;
    localparam int SCRUB_TIMEOUT = 15;
    localparam int SETTLE_CYC    = 2;
    localparam int CNT_MAX       = (1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [WIDTH-1:0]     copy_a = '0;
    logic [WIDTH-1:0]     copy_b = '0;
    logic [WIDTH-1:0]     copy_c = '0;
    logic                 scrub_ack = 1'b0;
    logic                 clr = 1'b0;
    logic [WIDTH-1:0]     voted;
    logic                 mismatch;
    logic                 scrub_req;
    logic [WIDTH-1:0]     scrub_data;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 err_sat;
    logic                 timeout_err;

    tmr_vote_scrubber #(
        .WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W),
        .SCRUB_TIMEOUT(SCRUB_TIMEOUT), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .copy_a(copy_a), .copy_b(copy_b), .copy_c(copy_c),
        .voted(voted), .mismatch(mismatch),
        .scrub_req(scrub_req), .scrub_data(scrub_data), .scrub_ack(scrub_ack),
        .clr(clr), .err_count(err_count), .err_sat(err_sat), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned voted;
        int unsigned mis;
        int unsigned req;
        int unsigned data;
        int unsigned cnt;
        int unsigned sat;
        int unsigned to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Behavioural model state
    typedef enum int {M_IDLE, M_WAIT_ACK, M_SETTLING, M_STUCK} mode_t;
    mode_t m_mode = M_IDLE;
    int unsigned m_voted = 0, m_mis = 0, m_req = 0, m_data = 0;
    int unsigned m_cnt = 0, m_sat = 0, m_to = 0;
    int m_waited = 0, m_settle_left = 0;

    function automatic int unsigned majority(input logic [WIDTH-1:0] a, b, c);
        int unsigned r = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (int'(a[i]) + int'(b[i]) + int'(c[i]) >= 2) r |= (1 << i);
        end
        return r;
    endfunction

    // Advance the model by one clock with the inputs about to be sampled.
    task automatic model_step();
        int unsigned maj;
        bit disagree;
        bit started;
        maj      = majority(copy_a, copy_b, copy_c);
        disagree = !((copy_a == copy_b) && (copy_b == copy_c));
        started  = 0;
        if (!rst_n) begin
            m_mode = M_IDLE; m_voted = 0; m_mis = 0; m_req = 0; m_data = 0;
            m_cnt = 0; m_sat = 0; m_to = 0; m_waited = 0; m_settle_left = 0;
            return;
        end
        m_voted = maj;
        m_mis   = disagree;
        case (m_mode)
            M_IDLE: if (disagree) begin
                m_data = maj; m_req = 1; m_waited = 0; m_mode = M_WAIT_ACK; started = 1;
            end
            M_WAIT_ACK: begin
                m_waited++;
                if (scrub_ack) begin
                    m_req = 0; m_settle_left = SETTLE_CYC; m_mode = M_SETTLING;
                end else if (m_waited >= SCRUB_TIMEOUT) begin
                    m_req = 0; m_to = 1; m_mode = M_STUCK;
                end
            end
            M_SETTLING: begin
                m_settle_left--;
                if (m_settle_left == 0) m_mode = M_IDLE;
            end
            M_STUCK: if (clr) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
        if (started && m_cnt < CNT_MAX) begin
            m_cnt++;
            if (m_cnt == CNT_MAX) m_sat = 1;
        end
        if (clr) begin
            m_cnt = 0; m_sat = 0; m_to = 0;
        end
    endtask

    // Drive one cycle of inputs and queue the outputs they should produce.
    task automatic step(input logic [WIDTH-1:0] a, b, c, input logic ack, cl, rn);
        exp_t e;
        @(negedge clk);
        copy_a = a; copy_b = b; copy_c = c;
        scrub_ack = ack; clr = cl; rst_n = rn;
        model_step();
        e.voted = m_voted; e.mis = m_mis; e.req = m_req; e.data = m_data;
        e.cnt = m_cnt; e.sat = m_sat; e.to = m_to;
        exp_q.push_back(e);
    endtask

    task automatic compare(input string name, input int unsigned act, input int unsigned exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL txn %0d %s: got %0h expected %0h", txn, name, act, exp_v);
        end
    endtask

    // Monitor: outputs are valid every cycle, compare just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                compare("voted",       int'(voted),       e.voted);
                compare("mismatch",    int'(mismatch),    e.mis);
                compare("scrub_req",   int'(scrub_req),   e.req);
                compare("scrub_data",  int'(scrub_data),  e.data);
                compare("err_count",   int'(err_count),   e.cnt);
                compare("err_sat",     int'(err_sat),     e.sat);
                compare("timeout_err", int'(timeout_err), e.to);
                $display("txn %0d voted=%02h mis=%0d req=%0d data=%02h cnt=%0d sat=%0d to=%0d",
                         txn, voted, mismatch, scrub_req, scrub_data, err_count, err_sat, timeout_err);
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] base, ra, rb, rc;
        // Reset, then clean input
        step(8'h00, 8'h00, 8'h00, 0, 0, 0);
        step(8'h00, 8'h00, 8'h00, 0, 0, 0);
        repeat (2) step(8'h5A, 8'h5A, 8'h5A, 0, 0, 1);
        // Single-copy upset, inputs wander while waiting, ack 3 cycles later
        step(8'h5A, 8'h5A, 8'h7A, 0, 0, 1);
        step(8'hFF, 8'h00, 8'hFF, 0, 0, 1);
        step(8'hFF, 8'h00, 8'hFF, 0, 0, 1);
        step(8'h5A, 8'h5A, 8'h5A, 1, 0, 1);
        step(8'h5A, 8'h5A, 8'h11, 0, 0, 1);   // ignored while settling
        step(8'h5A, 8'h5A, 8'h11, 0, 0, 1);
        step(8'h5A, 8'h5A, 8'h5A, 0, 0, 1);
        // Timeout into fault, mismatches in fault, then clr
        step(8'h5A, 8'h5A, 8'h5A, 0, 1, 1);
        repeat (20) step(8'h0F, 8'h0F, 8'h3F, 0, 0, 1);
        step(8'h0F, 8'h0F, 8'h3F, 0, 1, 1);
        step(8'h0F, 8'h0F, 8'h0F, 0, 0, 1);
        // Counter saturation: four acked events, then clr on a fifth start
        for (int k = 0; k < 4; k++) begin
            step(8'hA5, 8'hA4, 8'hA5, 0, 0, 1);
            step(8'hA5, 8'hA5, 8'hA5, 1, 0, 1);
            repeat (SETTLE_CYC) step(8'hA5, 8'hA5, 8'hA5, 0, 0, 1);
        end
        step(8'hA5, 8'hA4, 8'hA5, 0, 1, 1);
        step(8'hA5, 8'hA5, 8'hA5, 1, 0, 1);
        repeat (SETTLE_CYC + 1) step(8'hA5, 8'hA5, 8'hA5, 0, 0, 1);
        // Reset mid-handshake
        step(8'h33, 8'h31, 8'h33, 0, 0, 1);
        step(8'h33, 8'h33, 8'h33, 0, 0, 1);
        step(8'h33, 8'h33, 8'h33, 1, 0, 0);
        step(8'h33, 8'h33, 8'h33, 0, 0, 1);
        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            base = WIDTH'($urandom);
            ra = base; rb = base; rc = base;
            case ($urandom_range(0, 5))
                0: ra = base ^ WIDTH'($urandom);
                1: rb = base ^ WIDTH'($urandom);
                2: rc = base ^ WIDTH'($urandom);
                3: begin rb = WIDTH'($urandom); rc = WIDTH'($urandom); end
                default: ;
            endcase
            step(ra, rb, rc, ($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 299) != 0));
        end
        repeat (3) step(8'h00, 8'h00, 8'h00, 0, 1, 1);
        @(posedge clk);
        #2;
        compare("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
